// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch front end: fetch PC record, FSM states and queue entries.
package fetch_unit_pkg;

    localparam logic [3:0] RMASK_READ = 4'hF;
    localparam logic [3:0] RMASK_IDLE = 4'h0;

    typedef struct packed {
        logic [31:0] fetch_pc_curr;
        logic [31:0] fetch_pc_next;
    } fetch_output_reg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]       instr;
        fetch_output_reg_t pc;
    } fetch_queue_entry_t;

    function automatic fetch_output_reg_t make_fetch_pc(input logic [31:0] pc);
        fetch_output_reg_t r;
        r.fetch_pc_curr = pc;
        r.fetch_pc_next = pc + 32'd4;
        return r;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched instructions; flush empties it in one edge and wins over push/pop.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_queue_entry_t       wdata,
    output fetch_queue_entry_t       rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    fetch_queue_entry_t mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (count_r == {(PW+1){1'b0}});
    assign full      = (count_r == FULL_CNT);
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) mem_r[wr_ptr_r] <= wdata;
    end

endmodule

// File: rtl/fetch_unit_checker.sv
// Simulation checker for fetch_unit interface rules.
module fetch_unit_checker (
    input logic       clk,
    input logic       rst_n,
    input logic       redirect_valid,
    input logic [1:0] redirect_pc_lo
);

    a_redirect_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        redirect_valid |-> (redirect_pc_lo == 2'b00))
        else $error("redirect_pc not word aligned");

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, keeps one imem read in flight and queues returned words.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1eceb000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_fetch
);

    localparam int unsigned CW        = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    fetch_state_t       state_r;
    logic [31:0]        pc_r;
    logic [31:0]        addr_r;
    logic [3:0]         rmask_r;
    logic               pending_s;
    logic               redirect_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic [CW-1:0]      count_s;
    logic [CW-1:0]      count_next_s;
    fetch_queue_entry_t wdata_s;
    fetch_queue_entry_t head_s;

    assign pending_s  = (rmask_r == RMASK_READ);
    assign redirect_s = redirect_valid && (state_r != IDLE);
    assign push_s     = (state_r == FETCH) && pending_s && imem_resp && !redirect_s;
    assign out_valid  = !empty_s && !redirect_s;
    assign pop_s      = out_valid && out_ready;
    assign out_instr  = out_valid ? head_s.instr : 32'h0;
    assign out_fetch  = out_valid ? head_s.pc : 64'h0;
    assign imem_addr  = addr_r;
    assign imem_rmask = rmask_r;

    // Queue entry built from the returned word and the PC it was fetched from.
    always_comb begin
        wdata_s.instr = imem_rdata;
        wdata_s.pc    = make_fetch_pc(pc_r);
    end

    // Occupancy after this edge decides whether the follow-on request has a reserved slot.
    always_comb begin
        count_next_s = count_s;
        if (redirect_s) begin
            count_next_s = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_next_s = count_s + ONE_C;
        end else if (pop_s && !push_s) begin
            count_next_s = count_s - ONE_C;
        end else begin
            count_next_s = count_s;
        end
    end

    // Fetch FSM, fetch PC and registered memory request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pc_r    <= RESET_PC;
            addr_r  <= RESET_PC;
            rmask_r <= RMASK_IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= FETCH;
                    addr_r  <= pc_r;
                    rmask_r <= RMASK_READ;
                end
                FETCH: begin
                    if (redirect_valid) begin
                        pc_r <= redirect_pc;
                        if (pending_s && !imem_resp) begin
                            state_r <= FLUSH;
                        end else begin
                            addr_r  <= redirect_pc;
                            rmask_r <= RMASK_READ;
                        end
                    end else if (pending_s) begin
                        if (imem_resp) begin
                            pc_r    <= pc_r + 32'd4;
                            addr_r  <= pc_r + 32'd4;
                            rmask_r <= (count_next_s < DEPTH_C) ? RMASK_READ : RMASK_IDLE;
                        end
                    end else begin
                        addr_r  <= pc_r;
                        rmask_r <= (!full_s || pop_s) ? RMASK_READ : RMASK_IDLE;
                    end
                end
                FLUSH: begin
                    // The stale request stays on the bus until memory answers it.
                    if (redirect_valid) begin
                        pc_r <= redirect_pc;
                        if (imem_resp) begin
                            state_r <= FETCH;
                            addr_r  <= redirect_pc;
                            rmask_r <= RMASK_READ;
                        end
                    end else if (imem_resp) begin
                        state_r <= FETCH;
                        addr_r  <= pc_r;
                        rmask_r <= RMASK_READ;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    rmask_r <= RMASK_IDLE;
                end
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_s),
        .wdata (wdata_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected queue entries, a monitor checks each pop.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_fetch;

    int          vectors = 0;
    int          miscompares = 0;
    logic [95:0] exp_q [$];
    logic [95:0] mon_exp;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .FQ_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_fetch      (out_fetch)
    );

    fetch_unit_checker u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc_lo (redirect_pc[1:0])
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [95:0] entry_of(input logic [31:0] a);
        logic [31:0] nxt;
        nxt = a + 32'd4;
        return {word_of(a), a, nxt};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head must match the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got %h %h want none", out_instr, out_fetch);
            end else begin
                mon_exp = exp_q.pop_front();
                check("fifo_head", {out_instr, out_fetch}, mon_exp);
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (imem_rmask !== 4'hF && n < 20) begin
            tick();
            n++;
        end
        if (imem_rmask !== 4'hF) begin
            vectors++;
            miscompares++;
            $display("FAIL req_timeout: got rmask %h want f", imem_rmask);
        end
    endtask

    // Answer the next request one cycle after it appears.
    task automatic serve(input logic [31:0] a);
        wait_req();
        check("req_addr", imem_addr, a);
        tick();
        imem_resp  = 1'b1;
        imem_rdata = word_of(a);
        exp_q.push_back(entry_of(a));
        tick();
        imem_resp  = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_out_valid", out_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rmask"}, imem_rmask, 4'h0);
        check({tag, "_addr"}, imem_addr, RST_PC);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_instr"}, out_instr, 32'h0);
        check({tag, "_out_fetch"}, out_fetch, 64'h0);
    endtask

    task automatic do_reset();
        exp_q.delete();
        rst_n          = 1'b0;
        imem_resp      = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        imem_rdata     = 32'h0;
        imem_resp      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;

        // 1: reset state, sequential fetch with single-cycle memory
        tick();
        check_reset_outputs("t1_reset");
        rst_n = 1'b1;
        check("t1_idle_rmask", imem_rmask, 4'h0);
        tick();
        check("t1_first_req", imem_rmask, 4'hF);
        out_ready = 1'b1;
        serve(32'h1eceb000);
        serve(32'h1eceb004);
        serve(32'h1eceb008);
        drain();

        // 2: fill the queue with the decoder stalled, then free one slot
        do_reset();
        out_ready = 1'b0;
        serve(32'h1eceb000);
        serve(32'h1eceb004);
        serve(32'h1eceb008);
        serve(32'h1eceb00c);
        check("t2_full_rmask", imem_rmask, 4'h0);
        check("t2_full_addr", imem_addr, 32'h1eceb010);
        check("t2_full_valid", out_valid, 1'b1);
        tick();
        tick();
        check("t2_stall_hold", imem_rmask, 4'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_reissue_rmask", imem_rmask, 4'hF);
        check("t2_reissue_addr", imem_addr, 32'h1eceb010);
        serve(32'h1eceb010);
        check("t2_refull_rmask", imem_rmask, 4'h0);
        drain();

        // 3: redirect while a request is pending, response arrives later
        do_reset();
        out_ready = 1'b1;
        serve(32'h1eceb000);
        serve(32'h1eceb004);
        check("t3_pending_addr", imem_addr, 32'h1eceb008);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h60;
        exp_q.delete();
        tick();
        redirect_valid = 1'b0;
        check("t3_flush_addr", imem_addr, 32'h1eceb008);
        check("t3_flush_rmask", imem_rmask, 4'hF);
        check("t3_flush_valid", out_valid, 1'b0);
        tick();
        check("t3_flush_addr2", imem_addr, 32'h1eceb008);
        tick();
        imem_resp  = 1'b1;
        imem_rdata = word_of(32'h1eceb008);
        tick();
        imem_resp  = 1'b0;
        check("t3_new_addr", imem_addr, 32'h60);
        check("t3_new_rmask", imem_rmask, 4'hF);
        check("t3_new_valid", out_valid, 1'b0);
        serve(32'h60);
        drain();

        // 4: redirect coincides with the response
        do_reset();
        out_ready = 1'b1;
        serve(32'h1eceb000);
        wait_req();
        check("t4_pending_addr", imem_addr, 32'h1eceb004);
        tick();
        imem_resp      = 1'b1;
        imem_rdata     = word_of(32'h1eceb004);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        exp_q.delete();
        tick();
        imem_resp      = 1'b0;
        redirect_valid = 1'b0;
        check("t4_new_addr", imem_addr, 32'h100);
        check("t4_new_rmask", imem_rmask, 4'hF);
        check("t4_new_valid", out_valid, 1'b0);
        serve(32'h100);
        drain();

        // 5: PC wrap, push+pop at DEPTH-1, pop at full
        do_reset();
        out_ready = 1'b0;
        wait_req();
        tick();
        imem_resp      = 1'b1;
        imem_rdata     = word_of(RST_PC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFF0;
        exp_q.delete();
        tick();
        imem_resp      = 1'b0;
        redirect_valid = 1'b0;
        serve(32'hFFFFFFF0);
        serve(32'hFFFFFFF4);
        serve(32'hFFFFFFF8);
        wait_req();
        check("t5_top_addr", imem_addr, 32'hFFFFFFFC);
        tick();
        imem_resp  = 1'b1;
        imem_rdata = word_of(32'hFFFFFFFC);
        exp_q.push_back(entry_of(32'hFFFFFFFC));
        out_ready  = 1'b1;
        tick();
        imem_resp  = 1'b0;
        out_ready  = 1'b0;
        check("t5_wrap_addr", imem_addr, 32'h0);
        check("t5_wrap_rmask", imem_rmask, 4'hF);
        serve(32'h0);
        check("t5_full_rmask", imem_rmask, 4'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t5_pop_full_rmask", imem_rmask, 4'hF);
        check("t5_pop_full_addr", imem_addr, 32'h4);
        serve(32'h4);
        drain();

        // 6: asynchronous reset mid-request and mid-flush
        do_reset();
        out_ready = 1'b1;
        serve(32'h1eceb000);
        wait_req();
        check("t6_pending_addr", imem_addr, 32'h1eceb004);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_req_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_restart_rmask", imem_rmask, 4'hF);
        check("t6_restart_addr", imem_addr, RST_PC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("t6_flush_addr", imem_addr, RST_PC);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_flush_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_restart2_addr", imem_addr, RST_PC);
        serve(RST_PC);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
